// File: rtl/render_pkg.sv
// Shared renderer types and screen/texture geometry.
package render_pkg;

    localparam int unsigned SCREEN_W  = 320;
    localparam int unsigned SCREEN_H  = 240;
    localparam int unsigned TEX_DIM   = 16;
    localparam int unsigned TEX_WORDS = 128;

    typedef logic [11:0] rgb444_t;

    typedef struct packed {
        logic       transparent;
        logic [2:0] pad;
        rgb444_t    rgb;
    } tex_pixel_t;

    typedef enum logic {
        IDLE,
        RUN
    } blit_state_e;

endpackage

// File: rtl/tex_word_fifo.sv
// Return-data FIFO for texture words; push and pop may coincide at any occupancy.
module tex_word_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [AW:0]      count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && ((count != (AW+1)'(DEPTH)) || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/texture_blitter.sv
// Fetches a 16x16 RGB444 texture over Avalon-MM and streams clipped pixels.
// Define BLIT_TRANSPARENCY_EN to skip pixels whose transparent bit is set.
module texture_blitter
    import render_pkg::*;
#(
    parameter logic [31:0] TEX_BASE        = 32'h0800_0000,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [8:0]  cmd_x,
    input  logic [8:0]  cmd_y,
    input  logic [12:0] cmd_tex,
    output logic        busy,
    output logic        done,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic        master_waitrequest,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [11:0] pix_rgb
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;

    blit_state_e state_q, state_d;

    logic [8:0]    x_q;
    logic [8:0]    y_q;
    logic [31:0]   base_q;
    logic [7:0]    issued_q;
    logic [CW-1:0] outstanding_q;
    logic [8:0]    pix_cnt_q;
    logic [31:0]   word_q;
    logic          half_q;
    logic          have_q;

    logic          accept;
    logic          issue_ok;
    logic          issue;
    logic          fifo_push;
    logic          fifo_pop;
    logic [31:0]   fifo_data;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;

    tex_pixel_t    cur_pix;
    logic [9:0]    sx;
    logic [9:0]    sy;
    logic          skip;
    logic          retire;
    logic          last;
    logic          pad_unused;

    assign accept = cmd_valid && cmd_ready;

    // Words already returned but not yet unpacked still occupy FIFO slots,
    // so counting them here is what guarantees the FIFO cannot overflow.
    assign issue_ok  = !issued_q[7] &&
                       (({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW+1)'(MAX_OUTSTANDING));
    assign issue     = master_read && !master_waitrequest;
    assign fifo_push = master_readdatavalid && (outstanding_q != '0);

    assign master_address = base_q + {22'd0, issued_q, 2'b00};

    tex_word_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (master_readdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign cur_pix = half_q ? tex_pixel_t'(word_q[31:16]) : tex_pixel_t'(word_q[15:0]);
    assign sx      = {1'b0, x_q} + {6'd0, pix_cnt_q[3:0]};
    assign sy      = {1'b0, y_q} + {6'd0, pix_cnt_q[7:4]};

`ifdef BLIT_TRANSPARENCY_EN
    assign skip       = (sx >= 10'(SCREEN_W)) || (sy >= 10'(SCREEN_H)) || cur_pix.transparent;
    assign pad_unused = ^cur_pix.pad;
`else
    assign skip       = (sx >= 10'(SCREEN_W)) || (sy >= 10'(SCREEN_H));
    assign pad_unused = ^{cur_pix.transparent, cur_pix.pad};
`endif

    assign pix_valid = have_q && !skip;
    assign pix_x     = sx[8:0];
    assign pix_y     = sy[8:0];
    assign pix_rgb   = cur_pix.rgb;
    assign retire    = have_q && (skip || pix_ready);
    assign last      = retire && (pix_cnt_q == 9'd255);
    // Refill the unpacker as the high half retires so one pixel leaves per cycle.
    assign fifo_pop  = (state_q == RUN) && !fifo_empty && (!have_q || (retire && half_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        master_read = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy        = 1'b1;
                master_read = issue_ok;
                if (last) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q           <= '0;
            y_q           <= '0;
            base_q        <= '0;
            issued_q      <= '0;
            outstanding_q <= '0;
            pix_cnt_q     <= '0;
            word_q        <= '0;
            half_q        <= 1'b0;
            have_q        <= 1'b0;
        end else begin
            case ({issue, fifo_push})
                2'b10:   outstanding_q <= outstanding_q + CW'(1);
                2'b01:   outstanding_q <= outstanding_q - CW'(1);
                default: outstanding_q <= outstanding_q;
            endcase

            if (accept) begin
                x_q       <= cmd_x;
                y_q       <= cmd_y;
                base_q    <= TEX_BASE + {10'd0, cmd_tex, 9'd0};
                issued_q  <= '0;
                pix_cnt_q <= '0;
                half_q    <= 1'b0;
                have_q    <= 1'b0;
            end else begin
                if (issue) begin
                    issued_q <= issued_q + 8'd1;
                end
                if (retire) begin
                    pix_cnt_q <= pix_cnt_q + 9'd1;
                end
                if (fifo_pop) begin
                    word_q <= fifo_data;
                    half_q <= 1'b0;
                    have_q <= 1'b1;
                end else if (retire) begin
                    if (half_q) begin
                        have_q <= 1'b0;
                    end else begin
                        half_q <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_texture_blitter.sv
// Scoreboard bench for texture_blitter with a latency/wait-state memory model.
module tb_texture_blitter;
    import render_pkg::*;

    localparam logic [31:0] TEX_BASE = 32'h0800_0000;
    localparam int          MAXO     = 4;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [8:0]  cmd_x;
    logic [8:0]  cmd_y;
    logic [12:0] cmd_tex;
    logic        busy;
    logic        done;
    logic [31:0] master_address;
    logic        master_read;
    logic        master_waitrequest;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        pix_valid;
    logic        pix_ready;
    logic [8:0]  pix_x;
    logic [8:0]  pix_y;
    logic [11:0] pix_rgb;

    texture_blitter #(
        .TEX_BASE        (TEX_BASE),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_x                (cmd_x),
        .cmd_y                (cmd_y),
        .cmd_tex              (cmd_tex),
        .busy                 (busy),
        .done                 (done),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_waitrequest   (master_waitrequest),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .pix_valid            (pix_valid),
        .pix_ready            (pix_ready),
        .pix_x                (pix_x),
        .pix_y                (pix_y),
        .pix_rgb              (pix_rgb)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct packed {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [11:0] rgb;
    } pix_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } ret_t;

    pix_t        sb[$];
    ret_t        pend[$];

    int          n_cmp = 0;
    int          n_mis = 0;
    int          cfg_wait = 0;
    int          cfg_lat = 2;
    int          cfg_rdy = 0;
    bit          cfg_transp = 1'b0;
    logic [31:0] exp_base = '0;
    int          n_issued = 0;
    int          pix_hs = 0;
    int          done_cnt = 0;
    int          acc_cyc = 0;
    int          done_cyc = 0;
    int          oust = 0;
    int          cyc = 0;
    int          stall = 0;
    int          exp_n = 0;
    logic [31:0] first_addr = '0;
    pix_t        last_pix = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] tex_pix(input int tex, input int p);
        logic [11:0] rgb;
        rgb = 12'(tex * 7 + p);
        return {(cfg_transp && (p % 2 == 1)), 3'b101, rgb};
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        logic [31:0] off;
        int          tex;
        int          k;
        off = addr - TEX_BASE;
        tex = int'(off >> 9);
        k   = int'((off >> 2) & 32'd127);
        return {tex_pix(tex, 2 * k + 1), tex_pix(tex, 2 * k)};
    endfunction

    // Memory slave, pixel sink and scoreboard checker, all stepped at negedge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            pix_ready            = (cfg_rdy == 0) || (cyc % 3 == 0);
            master_readdatavalid = 1'b0;
            master_readdata      = '0;
            master_waitrequest   = 1'b0;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                master_readdatavalid = 1'b1;
                master_readdata      = pend[0].data;
                void'(pend.pop_front());
                if (oust > 0) oust--;
            end
            if (rst_n && master_read) begin
                check("addr", master_address, exp_base + 32'(4 * n_issued));
                if (stall < cfg_wait) begin
                    master_waitrequest = 1'b1;
                    stall++;
                end else begin
                    stall = 0;
                    if (n_issued == 0) first_addr = master_address;
                    pend.push_back('{cyc + cfg_lat, mem_word(master_address)});
                    n_issued++;
                    oust++;
                    check("outstanding_le_max", 32'(oust <= MAXO), 32'd1);
                end
            end else begin
                stall = 0;
            end
            #1;
            if (rst_n) begin
                if (cmd_valid && cmd_ready) acc_cyc = cyc;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (pix_valid) begin
                    if (sb.size() == 0) begin
                        check("pix_unexpected", 32'({pix_x, pix_y, pix_rgb}), '1);
                    end else begin
                        check("pix", 32'({pix_x, pix_y, pix_rgb}), 32'(sb[0]));
                        if (pix_ready) begin
                            last_pix = {pix_x, pix_y, pix_rgb};
                            void'(sb.pop_front());
                            pix_hs++;
                        end
                    end
                end
            end
        end
    end

    task automatic start_blit(input int x, input int y, input int tex,
                              input int wt, input int lat, input int rdy, input bit tr);
        int          sx;
        int          sy;
        logic [15:0] pv;
        bit          skip;
        cfg_wait   = wt;
        cfg_lat    = lat;
        cfg_rdy    = rdy;
        cfg_transp = tr;
        n_issued   = 0;
        pix_hs     = 0;
        done_cnt   = 0;
        stall      = 0;
        exp_base   = TEX_BASE + 32'(tex * 512);
        sb.delete();
        exp_n = 0;
        for (int p = 0; p < 256; p++) begin
            sx   = x + p % 16;
            sy   = y + p / 16;
            pv   = tex_pix(tex, p);
            skip = (sx >= 320) || (sy >= 240);
`ifdef BLIT_TRANSPARENCY_EN
            skip = skip || pv[15];
`endif
            if (!skip) begin
                sb.push_back('{9'(sx), 9'(sy), pv[11:0]});
                exp_n++;
            end
        end
        cmd_x     = 9'(x);
        cmd_y     = 9'(y);
        cmd_tex   = 13'(tex);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("accept_busy_ready_read", 32'({busy, cmd_ready, master_read}), 32'b101);
    endtask

    task automatic finish_blit();
        for (int i = 0; i < 20000 && done_cnt == 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("reads_issued", 32'(n_issued), 32'd128);
        check("pix_count", 32'(pix_hs), 32'(exp_n));
        check("idle_after", 32'({busy, cmd_ready}), 32'b01);
    endtask

    initial begin
        rst_n                = 1'b0;
        cmd_valid            = 1'b0;
        cmd_x                = '0;
        cmd_y                = '0;
        cmd_tex              = '0;
        pix_ready            = 1'b1;
        master_waitrequest   = 1'b0;
        master_readdata      = '0;
        master_readdatavalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_master_read", 32'(master_read), 32'd0);
        check("rst_master_address", master_address, 32'd0);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_xy", 32'({pix_x, pix_y}), 32'd0);
        check("rst_pix_rgb", 32'(pix_rgb), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full texture at origin, zero wait, latency 2
        start_blit(0, 0, 0, 0, 2, 0, 1'b0);
        finish_blit();
        check("blit_cycles", 32'(done_cyc - acc_cyc + 1), 32'(256 + 2 + 3));
        check("last_pixel", 32'(last_pix), 32'({9'd15, 9'd15, 12'h0FF}));

        // Bottom-right corner clipping
        start_blit(312, 232, 3, 0, 2, 0, 1'b0);
        finish_blit();
        check("clip_count", 32'(pix_hs), 32'd64);
        check("clip_last", 32'({last_pix.x, last_pix.y}), 32'({9'd319, 9'd239}));

        // Wait states and long latency
        start_blit(0, 0, 0, 3, 10, 0, 1'b0);
        finish_blit();

        // Sink backpressure, ready one cycle in three
        start_blit(100, 50, 1, 0, 3, 1, 1'b0);
        finish_blit();

        // Odd pixels flagged transparent
        start_blit(0, 0, 2, 0, 2, 0, 1'b1);
        finish_blit();
`ifdef BLIT_TRANSPARENCY_EN
        check("transp_count", 32'(pix_hs), 32'd128);
`else
        check("transp_count", 32'(pix_hs), 32'd256);
`endif

        // Abort mid-blit, then a fresh blit of texture 5
        start_blit(0, 0, 0, 0, 10, 0, 1'b0);
        for (int i = 0; i < 5000 && pix_hs < 100; i++) @(posedge clk);
        check("reached_pix100", 32'(pix_hs >= 100), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_state", 32'({cmd_ready, busy, master_read, pix_valid}), 32'b1000);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 100 && pend.size() > 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("stale_drained", 32'(pend.size()), 32'd0);
        check("abort_idle_no_read", 32'({cmd_ready, master_read}), 32'b10);
        start_blit(0, 0, 5, 0, 2, 0, 1'b0);
        finish_blit();
        check("tex5_first_addr", first_addr, 32'h0800_0A00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/texture_blitter.md
# texture_blitter

Fetches one 16x16 RGB444 texture from memory over an Avalon-MM read master and emits its pixels, clipped to the 320x240 screen, as a ready/valid pixel-write stream into the renderer's frame buffer. Sits directly upstream of the renderer's frame buffer. The renderer's CPU slave decodes the coordinates/tex_code/plot registers and issues one blit command per plot. Up to MAX_OUTSTANDING reads are kept in flight so the blit is not latency-bound.

## Interface
- TEX_BASE, 32'h0800_0000: byte address of texture 0.
- MAX_OUTSTANDING, 4: maximum issued-but-unreturned reads; also the return FIFO depth; power of 2, range 2..8.
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  blit request.
- cmd_ready  out  1  high only in IDLE.
- cmd_x  in  9  texture top-left x, 0..511.
- cmd_y  in  9  texture top-left y, 0..511.
- cmd_tex  in  13  texture code.
- busy  out  1  high from command accept until the last pixel handshake.
- done  out  1  one-cycle pulse on the cycle busy falls.
- master_address  out  32  word-aligned byte address.
- master_read  out  1  read request.
- master_waitrequest  in  1  Avalon stall.
- master_readdata  in  32  return data.
- master_readdatavalid  in  1  return strobe; returns arrive in order.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  frame buffer accepts.
- pix_x  out  9  screen x.
- pix_y  out  9  screen y.
- pix_rgb  out  12  RRRR_GGGG_BBBB.

## Operation
- Memory format: word k (0..127) is at TEX_BASE + cmd_tex*512 + 4*k. Pixels are in row-major order.
  - Row = k>>3, col = 2*(k&7).
  - Bits [15:0] hold pixel col; bits [31:16] hold pixel col+1.
  - Each 16-bit pixel: bit 15 = transparent flag, bits [11:0] = RGB, bits [14:12] ignored.
- States: IDLE, RUN.
  - IDLE -> RUN on cmd_valid && cmd_ready. x, y and base address are latched.
  - In RUN, the issue counter (0..128) and pixel counter (0..256) are cleared.
  - RUN -> IDLE on the handshake or skip of pixel 255. done pulses that cycle.
- Issue rule: master_read is asserted while issued < 128 and (outstanding + fifo_count) < MAX_OUTSTANDING.
  - A read counts as issued on master_read && !master_waitrequest.
  - master_address and master_read stay stable while waitrequest is high.
  - Each readdatavalid pushes one word into the return FIFO and decrements outstanding. The FIFO never overflows by construction.
  - readdatavalid while IDLE with outstanding == 0 is dropped.
- Unpacker: pops one FIFO word and presents the low half, then the high half.
  - Screen coordinates: sx = x + col, sy = y + row, computed 10 bits wide.
  - Clip: a pixel with sx >= 320 or sy >= 240 is skipped. A skip consumes one cycle, with no pix_valid.
- pix_valid, pix_x, pix_y and pix_rgb are held stable until pix_ready. A pixel retires on pix_valid && pix_ready.
- A new command is never accepted while busy.

## Timing
- Reset values: cmd_ready=1, busy=0, done=0, master_read=0, master_address=0, pix_valid=0, pix_x=0, pix_y=0, pix_rgb=0. All counters cleared and the FIFO is emptied.
- Reset mid-blit aborts immediately to IDLE. Late returns are dropped under the IDLE/outstanding==0 rule.
- master_read asserts the cycle after command accept.
- The first pix_valid comes no earlier than 1 cycle after the first readdatavalid. The registered FIFO pop adds 1 cycle.
- Throughput: 1 pixel (emit or skip) per cycle when the FIFO is non-empty and pix_ready=1.
  - Zero-wait memory and pix_ready=1 gives a blit of 256 + memory latency + 3 cycles.
- Simultaneous push and pop in the same cycle is legal at any FIFO occupancy.
- Simultaneous issue and return: outstanding is unchanged.

## Configuration
- BLIT_TRANSPARENCY_EN defined: pixels with bit 15 set are skipped, exactly as for clipped pixels.
- BLIT_TRANSPARENCY_EN undefined: bit 15 is ignored and every unclipped pixel is emitted.

## Structure
- Package render_pkg: SCREEN_W=320, SCREEN_H=240, TEX_DIM=16, TEX_WORDS=128, typedef rgb444_t (12 bits), typedef tex_pixel_t (packed struct: transparent bit, 3-bit pad, rgb444_t), typedef blit_state_e.
- Sub-module tex_word_fifo: synchronous FIFO, depth MAX_OUTSTANDING, 32 bits wide, with count output.

## Test plan
- Blit tex 0 at (0,0); memory returns pixel value = index, opaque; zero wait, latency 2 -> 256 pixels in raster order, (15,15) rgb=12'h0FF, one done pulse.
- Blit at (312,232) -> exactly 64 pixels emitted (x 312..319, y 232..239), all 128 words still read.
- waitrequest high 3 cycles per read, latency 10 -> never more than 4 outstanding; address stable while stalled; output identical to the first test.
- pix_ready toggling 1-of-3 cycles -> no pixel lost or duplicated; outputs stable while stalled.
- With BLIT_TRANSPARENCY_EN, odd pixels transparent -> 128 pixels, all even x; without it -> 256.
- rst_n low at pixel 100 with 2 reads outstanding, then a new blit of tex 5 -> stale returns ignored; addresses start at 32'h0800_0A00.
